// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - up/down counter/timer core with prescaler, modulus and wrap/saturate/one-shot modes
module updown_counter_mod #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             oe,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] cmp,
    input  logic [PSC_W-1:0] psc,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             match,
    output logic             ovf,
    output logic             done
);

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic [PSC_W-1:0] psc_cnt;
    logic             active;
    logic             tick;
    logic             at_bound;
    logic             wrap_mode;
    logic             wrap_evt;
    logic             oneshot_evt;

    // A finished one-shot freezes both the prescaler and the count.
    assign active      = en & ~clr & ~load & ~done;
    assign tick        = active & (psc_cnt == psc);
    assign at_bound    = up ? (count >= limit) : (count == '0);
    assign wrap_mode   = (mode != MODE_SAT) && (mode != MODE_ONESHOT);
    assign wrap_evt    = tick & at_bound & wrap_mode;
    assign oneshot_evt = tick & at_bound & (mode == MODE_ONESHOT);

    assign tc = reset_n & tick & at_bound;
    assign y  = oe ? count : '0;

    always_comb begin
        count_nxt = count;
        if (tick) begin
            if (!at_bound) begin
                count_nxt = up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
            end else if (wrap_mode) begin
                count_nxt = up ? '0 : limit;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            psc_cnt <= '0;
            match   <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else if (clr) begin
            count   <= '0;
            psc_cnt <= '0;
            match   <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else if (load) begin
            count   <= d;
            psc_cnt <= '0;
            match   <= (d == cmp);
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            // Only a real change of value can pulse match; held counts stay quiet.
            match <= tick && (count_nxt != count) && (count_nxt == cmp);
            if (active) begin
                psc_cnt <= tick ? '0 : (psc_cnt + PSC_W'(1));
                count   <= count_nxt;
            end
            if (wrap_evt) begin
                ovf <= 1'b1;
            end
            if (oneshot_evt) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - directed scoreboard bench for updown_counter_mod
module tb_updown_counter_mod;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       clr;
    logic       load;
    logic       up;
    logic [1:0] mode;
    logic       oe;
    logic [7:0] d;
    logic [7:0] limit;
    logic [7:0] cmp;
    logic [3:0] psc;
    logic [7:0] y;
    logic       tc;
    logic       match;
    logic       ovf;
    logic       done;

    int tests;
    int failed;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    updown_counter_mod #(.WIDTH(8), .PSC_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load), .up(up),
        .mode(mode), .oe(oe), .d(d), .limit(limit), .cmp(cmp), .psc(psc),
        .y(y), .tc(tc), .match(match), .ovf(ovf), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_y(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    // One clock; the oldest queued expectation is compared against y after the edge.
    task automatic step();
        string       t;
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, 32'(y), e);
        end
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        reset_n = 1'b0;
        en      = 1'b1;
        clr     = 1'b0;
        load    = 1'b0;
        up      = 1'b0;
        mode    = 2'b00;
        oe      = 1'b1;
        d       = 8'd0;
        limit   = 8'd255;
        cmp     = 8'd0;
        psc     = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_y", 32'(y), 0);
        check("reset_tc", 32'(tc), 0);
        check("reset_match", 32'(match), 0);
        check("reset_ovf", 32'(ovf), 0);
        check("reset_done", 32'(done), 0);
        reset_n = 1'b1;
        up      = 1'b1;

        // Full-range wrap up
        for (int i = 1; i <= 255; i++) begin
            push_y("t1_count", i);
            step();
        end
        check("t1_tc_at_255", 32'(tc), 1);
        check("t1_ovf_before", 32'(ovf), 0);
        push_y("t1_wrap_y", 0);
        step();
        check("t1_ovf_after", 32'(ovf), 1);

        // Prescaler and enable hold
        clr = 1'b1;
        push_y("t2_clr_y", 0);
        step();
        check("t2_clr_ovf", 32'(ovf), 0);
        clr   = 1'b0;
        psc   = 4'd3;
        limit = 8'd9;
        for (int n = 1; n <= 10; n++) begin
            push_y("t2_psc", n / 4);
            step();
        end
        en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            push_y("t2_hold", 2);
            step();
        end
        en = 1'b1;
        push_y("t2_resume_a", 2);
        step();
        push_y("t2_resume_b", 3);
        step();

        // Saturate down from 2
        mode  = 2'b01;
        up    = 1'b0;
        psc   = 4'd0;
        load  = 1'b1;
        d     = 8'd2;
        push_y("t3_load", 2);
        step();
        load = 1'b0;
        #1;
        check("t3_tc_2", 32'(tc), 0);
        push_y("t3_y1", 1);
        step();
        #1;
        check("t3_tc_1", 32'(tc), 0);
        push_y("t3_y0", 0);
        step();
        #1;
        check("t3_tc_0a", 32'(tc), 1);
        push_y("t3_sat_a", 0);
        step();
        #1;
        check("t3_tc_0b", 32'(tc), 1);
        push_y("t3_sat_b", 0);
        step();
        check("t3_ovf", 32'(ovf), 0);

        // One-shot up to 5
        mode  = 2'b10;
        up    = 1'b1;
        limit = 8'd5;
        load  = 1'b1;
        d     = 8'd0;
        push_y("t4_load", 0);
        step();
        load = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            push_y("t4_count", n);
            step();
        end
        check("t4_done_early", 32'(done), 0);
        push_y("t4_end", 5);
        step();
        check("t4_done", 32'(done), 1);
        #1;
        check("t4_tc_done", 32'(tc), 0);
        push_y("t4_frozen_a", 5);
        step();
        push_y("t4_frozen_b", 5);
        step();
        load = 1'b1;
        push_y("t4_reload", 0);
        step();
        check("t4_done_clr", 32'(done), 0);
        load = 1'b0;
        push_y("t4_resume", 1);
        step();

        // Compare match
        mode  = 2'b00;
        limit = 8'd20;
        cmp   = 8'd7;
        load  = 1'b1;
        d     = 8'd5;
        push_y("t5_load5", 5);
        step();
        check("t5_match_load5", 32'(match), 0);
        load = 1'b0;
        push_y("t5_y6", 6);
        step();
        check("t5_match_6", 32'(match), 0);
        push_y("t5_y7", 7);
        step();
        check("t5_match_7", 32'(match), 1);
        push_y("t5_y8", 8);
        step();
        check("t5_match_8", 32'(match), 0);
        load  = 1'b1;
        d     = 8'd7;
        limit = 8'd7;
        mode  = 2'b01;
        push_y("t5_load7", 7);
        step();
        check("t5_match_load7", 32'(match), 1);
        load = 1'b0;
        push_y("t5_sat_a", 7);
        step();
        check("t5_match_sat_a", 32'(match), 0);
        push_y("t5_sat_b", 7);
        step();
        check("t5_match_sat_b", 32'(match), 0);

        // clr beats load; load above limit; oe; limit=0; async reset
        clr  = 1'b1;
        load = 1'b1;
        d    = 8'd50;
        push_y("t6_clr_load", 0);
        step();
        check("t6_clr_match", 32'(match), 0);
        clr   = 1'b0;
        d     = 8'd200;
        limit = 8'd100;
        mode  = 2'b00;
        cmp   = 8'd9;
        push_y("t6_load200", 200);
        step();
        check("t6_ovf_pre", 32'(ovf), 0);
        load = 1'b0;
        #1;
        check("t6_tc_above", 32'(tc), 1);
        push_y("t6_wrap", 0);
        step();
        check("t6_ovf", 32'(ovf), 1);
        push_y("t6_y1", 1);
        step();
        push_y("t6_y2", 2);
        step();
        oe = 1'b0;
        #1;
        check("t6_oe_off", 32'(y), 0);
        oe = 1'b1;
        #1;
        check("t6_oe_on", 32'(y), 2);

        limit = 8'd0;
        clr   = 1'b1;
        push_y("t6_lim0_clr", 0);
        step();
        clr = 1'b0;
        check("t6_lim0_ovf_pre", 32'(ovf), 0);
        push_y("t6_lim0", 0);
        step();
        check("t6_lim0_ovf", 32'(ovf), 1);

        limit = 8'd100;
        push_y("t6_run1", 1);
        step();
        push_y("t6_run2", 2);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_y", 32'(y), 0);
        check("t6_rst_ovf", 32'(ovf), 0);
        check("t6_rst_tc", 32'(tc), 0);
        psc = 4'd2;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push_y("t6_rel_a", 0);
        step();
        push_y("t6_rel_b", 0);
        step();
        push_y("t6_rel_c", 1);
        step();

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
